// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word, RAM status and the arbiter's grant states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache: registered grant FSM with
// dcache priority, bounded dcache bursts, icache starvation guard and a bus timeout.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DBURST_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        bus_err
);

  localparam int BW = $clog2(DBURST_MAX) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_DGRANT = DGRANT;
  localparam logic [1:0] ST_IGRANT = IGRANT;
  localparam logic [1:0] RS_ACCESS = ACCESS;
  localparam logic [1:0] RS_ERROR  = ERROR;

  localparam logic [BW-1:0] BURST_LAST = BW'(DBURST_MAX - 1);
  localparam logic [TW-1:0] TO_LIMIT   = TW'(TIMEOUT);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [BW-1:0] r_burst_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_ifirst;
  logic          r_bus_err;

  logic w_dreq;
  logic w_access;
  logic w_granted;
  logic w_req_live;
  logic w_timeout;
  logic w_burst_more;

  assign w_dreq       = dREN | dWEN;
  assign w_access     = (ramstate == RS_ACCESS);
  assign w_granted    = (r_state == ST_DGRANT) | (r_state == ST_IGRANT);
  assign w_req_live   = (r_state == ST_DGRANT) ? w_dreq : iREN;
  assign w_timeout    = w_granted & w_req_live & ~w_access & (r_to_cnt == TO_LIMIT);
  assign w_burst_more = (r_burst_cnt < BURST_LAST);

  assign iload   = ramload;
  assign dload   = ramload;
  assign bus_err = r_bus_err;

  // Next-state selection; ifirst lets a waiting icache jump ahead once after a full dcache burst.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_dreq && !r_ifirst) begin
          w_next = ST_DGRANT;
        end else if (iREN) begin
          w_next = ST_IGRANT;
        end else if (w_dreq) begin
          w_next = ST_DGRANT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_DGRANT: begin
        if (!w_dreq || w_timeout) begin
          w_next = ST_IDLE;
        end else if (w_access) begin
          w_next = w_burst_more ? ST_DGRANT : ST_IDLE;
        end else begin
          w_next = ST_DGRANT;
        end
      end
      ST_IGRANT: begin
        if (!iREN || w_access || w_timeout) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_IGRANT;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Grant state plus burst/timeout counters, starvation flag and sticky error.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= {BW{1'b0}};
      r_to_cnt    <= {TW{1'b0}};
      r_ifirst    <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state <= w_next;

      if (r_state == ST_DGRANT && w_next == ST_DGRANT && w_access) begin
        r_burst_cnt <= r_burst_cnt + BW'(1);
      end else if (w_next != ST_DGRANT) begin
        r_burst_cnt <= {BW{1'b0}};
      end else begin
        r_burst_cnt <= r_burst_cnt;
      end

      // Saturating count of stalled cycles within the current grant.
      if (w_granted && (w_next == r_state) && !w_access) begin
        r_to_cnt <= (r_to_cnt == TO_LIMIT) ? r_to_cnt : r_to_cnt + TW'(1);
      end else begin
        r_to_cnt <= {TW{1'b0}};
      end

      if (r_state == ST_IGRANT && iREN && w_access) begin
        r_ifirst <= 1'b0;
      end else if (r_state == ST_DGRANT && w_dreq && w_access && !w_burst_more) begin
        r_ifirst <= r_ifirst | iREN;
      end else begin
        r_ifirst <= r_ifirst;
      end

      if (w_granted && ((ramstate == RS_ERROR) || w_timeout)) begin
        r_bus_err <= 1'b1;
      end else begin
        r_bus_err <= r_bus_err;
      end
    end
  end

  // RAM port and wait mux; the granted cache drives the RAM combinationally.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    case (r_state)
      ST_DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~w_access;
      end
      ST_IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = ~w_access;
      end
      default: begin
        iwait = 1'b1;
        dwait = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a grant-level model checked every cycle plus
// hand-computed expectations at the key points of each scenario.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TO = 255;
  localparam int DB = 4;
  localparam int G_NONE = 0;
  localparam int G_D    = 1;
  localparam int G_I    = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, bus_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses;
  bit cmp_en   = 1'b0;

  // model state: who owns the RAM, accesses done and stalled cycles in this grant
  int m_grant = G_NONE;
  int m_done  = 0;
  int m_stall = 0;
  bit m_ipend = 1'b0;
  bit m_err   = 1'b0;

  logic        e_iw, e_dw, e_rd, e_wr;
  logic [31:0] e_addr, e_st;

  wire dreq = dREN | dWEN;
  wire acc  = (ramstate == ACCESS);

  mem_arbiter #(.DBURST_MAX(DB), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    ramload = 32'hA5A5_0000 ^ 32'(cyc);
  endtask

  // Model update from the request/RAM status seen at each edge.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_grant <= G_NONE; m_done <= 0; m_stall <= 0; m_ipend <= 1'b0; m_err <= 1'b0;
    end else begin
      case (m_grant)
        G_D, G_I: begin
          if (ramstate == ERROR) m_err <= 1'b1;
          if (!((m_grant == G_D) ? dreq : iREN)) begin
            m_grant <= G_NONE; m_done <= 0; m_stall <= 0;
          end else if (acc) begin
            m_stall <= 0;
            if (m_grant == G_I) begin
              m_grant <= G_NONE; m_ipend <= 1'b0;
            end else if (m_done + 1 == DB) begin
              m_grant <= G_NONE; m_done <= 0;
              if (iREN) m_ipend <= 1'b1;
            end else begin
              m_done <= m_done + 1;
            end
          end else if (m_stall == TO) begin
            m_err <= 1'b1; m_grant <= G_NONE; m_stall <= 0; m_done <= 0;
          end else begin
            m_stall <= m_stall + 1;
          end
        end
        default: begin
          if (dreq && !m_ipend) m_grant <= G_D;
          else if (iREN) m_grant <= G_I;
          else if (dreq) m_grant <= G_D;
          m_done <= 0; m_stall <= 0;
        end
      endcase
    end
  end

  // Expected port values for the current owner.
  always_comb begin
    e_iw = 1'b1; e_dw = 1'b1; e_rd = 1'b0; e_wr = 1'b0; e_addr = 32'h0; e_st = 32'h0;
    if (m_grant == G_D) begin
      e_wr = dWEN; e_rd = dREN & ~dWEN; e_addr = daddr; e_st = dstore; e_dw = ~acc;
    end else if (m_grant == G_I) begin
      e_rd = iREN; e_addr = iaddr; e_iw = ~acc;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("cyc_iwait", iwait, e_iw);
      chk("cyc_dwait", dwait, e_dw);
      chk("cyc_ramREN", ramREN, e_rd);
      chk("cyc_ramWEN", ramWEN, e_wr);
      chk("cyc_ramaddr", ramaddr, e_addr);
      chk("cyc_ramstore", ramstore, e_st);
      chk("cyc_bus_err", bus_err, m_err);
      chk("cyc_iload", iload, ramload);
      chk("cyc_dload", dload, ramload);
    end
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0; ramstate = FREE;
    #1 cmp_en = 1'b1;
    step(); step();
    nRST = 1'b1;
    #2 chk("rst_iwait", iwait, 1'b1); chk("rst_dwait", dwait, 1'b1);
    chk("rst_ramaddr", ramaddr, 32'h0); chk("rst_bus_err", bus_err, 1'b0);

    // simultaneous requests: dcache first, icache afterwards
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h100; iaddr = 32'h200;
    #2 chk("s1_c0_ramREN", ramREN, 1'b0);
    step(); ramstate = BUSY;
    #2 chk("s1_c1_ramaddr", ramaddr, 32'h100); chk("s1_c1_ramREN", ramREN, 1'b1);
    step(); ramstate = BUSY;
    #2 chk("s1_c2_dwait", dwait, 1'b1);
    step(); ramstate = ACCESS;
    #2 chk("s1_c3_dwait", dwait, 1'b0); chk("s1_c3_iwait", iwait, 1'b1);
    step(); dREN = 1'b0; ramstate = FREE;
    #2 chk("s1_c4_dwait", dwait, 1'b1);
    step();
    #2 chk("s1_c5_ramREN", ramREN, 1'b0); chk("s1_c5_model", 32'(m_grant), 32'(G_NONE));
    step(); ramstate = ACCESS;
    #2 chk("s1_c6_ramaddr", ramaddr, 32'h200); chk("s1_c6_iwait", iwait, 1'b0);
    step(); iREN = 1'b0; ramstate = FREE;
    #2 chk("s1_c7_ramREN", ramREN, 1'b0);

    // dcache burst of four while icache waits
    step(); iREN = 1'b1; iaddr = 32'h400; dREN = 1'b1; daddr = 32'h10;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      step(); daddr = 32'h10 + 32'(k); ramstate = (k < 4) ? ACCESS : FREE;
      #2 if (!dwait) pulses++;
    end
    chk("s2_pulses", 32'(pulses), 32'd4);
    chk("s2_c5_ramREN", ramREN, 1'b0);
    chk("s2_model_ipend", 32'(m_ipend), 32'd1);
    step(); ramstate = ACCESS;
    #2 chk("s2_c6_ramaddr", ramaddr, 32'h400); chk("s2_c6_iwait", iwait, 1'b0);
    chk("s2_c6_dwait", dwait, 1'b1);
    step(); iREN = 1'b0; ramstate = FREE;
    #2 chk("s2_c7_ramREN", ramREN, 1'b0);
    step(); ramstate = ACCESS;
    #2 chk("s2_c8_ramaddr", ramaddr, 32'h14); chk("s2_c8_dwait", dwait, 1'b0);
    step(); dREN = 1'b0; ramstate = FREE;
    step();

    // write wins over read
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h3100; dstore = 32'hDEAD_BEEF;
    step(); ramstate = BUSY;
    #2 chk("s3_ramWEN", ramWEN, 1'b1); chk("s3_ramREN", ramREN, 1'b0);
    chk("s3_ramstore", ramstore, 32'hDEAD_BEEF); chk("s3_ramaddr", ramaddr, 32'h3100);
    step(); ramstate = ACCESS;
    #2 chk("s3_dwait", dwait, 1'b0);
    step(); dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    step();

    // one ERROR cycle then ACCESS
    dREN = 1'b1; daddr = 32'h50;
    step(); ramstate = ERROR;
    #2 chk("s4_err_dwait", dwait, 1'b1); chk("s4_err_ramREN", ramREN, 1'b1);
    chk("s4_err_bus_err", bus_err, 1'b0);
    step(); ramstate = ACCESS;
    #2 chk("s4_acc_bus_err", bus_err, 1'b1); chk("s4_acc_dwait", dwait, 1'b0);
    step(); dREN = 1'b0; ramstate = FREE;
    #2 chk("s4_after_dwait", dwait, 1'b1);
    step();

    // async reset in the middle of a dcache BUSY cycle
    dREN = 1'b1; daddr = 32'h60;
    step(); ramstate = BUSY;
    #2 chk("s5_pre_ramaddr", ramaddr, 32'h60);
    nRST = 1'b0;
    #1 chk("s5_iwait", iwait, 1'b1); chk("s5_dwait", dwait, 1'b1);
    chk("s5_ramREN", ramREN, 1'b0); chk("s5_ramWEN", ramWEN, 1'b0);
    chk("s5_ramaddr", ramaddr, 32'h0); chk("s5_bus_err", bus_err, 1'b0);
    step(); nRST = 1'b1; dREN = 1'b0; ramstate = FREE;
    step();

    // icache held BUSY until the timeout fires
    iREN = 1'b1; iaddr = 32'h70;
    pulses = 0;
    for (int k = 1; k <= TO + 2; k++) begin
      step(); ramstate = BUSY;
      #2 if (!iwait) pulses++;
      if (k == TO + 1) begin
        chk("s6_last_bus_err", bus_err, 1'b0); chk("s6_last_ramREN", ramREN, 1'b1);
      end
      if (k == TO + 2) begin
        chk("s6_to_bus_err", bus_err, 1'b1); chk("s6_to_ramREN", ramREN, 1'b0);
      end
    end
    chk("s6_pulses", 32'(pulses), 32'd0);
    step(); iREN = 1'b0; ramstate = FREE;
    step();

    // dcache drops its request while BUSY; waiting icache goes next
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h80; iaddr = 32'h90;
    step(); ramstate = BUSY;
    #2 chk("s7_c1_ramaddr", ramaddr, 32'h80);
    step(); dREN = 1'b0;
    #2 chk("s7_c2_dwait", dwait, 1'b1); chk("s7_c2_ramREN", ramREN, 1'b0);
    step(); ramstate = FREE;
    #2 chk("s7_c3_ramREN", ramREN, 1'b0); chk("s7_c3_iwait", iwait, 1'b1);
    step(); ramstate = ACCESS;
    #2 chk("s7_c4_ramaddr", ramaddr, 32'h90); chk("s7_c4_iwait", iwait, 1'b0);
    step(); iREN = 1'b0; ramstate = FREE;
    step(); step();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
